// File: rtl/auto_contrast_stats.sv
// auto_contrast_stats
//   Gathers per-frame luma min/max and turns them into auto-contrast
//   coefficients:
//     alpha = floor(65280 / (max - min))     (8.8 unsigned gain)
//     beta  = -((min * alpha) >> 8) mod 2^16 (two's complement offset)
//   A flat frame (max == min) yields the identity: alpha = 0x0100, beta = 0.
//
// Ports
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   frame_start  one-cycle pulse; restarts statistics, abandons any computation
//   frame_end    one-cycle pulse; closes the frame (only honoured in ACCUM)
//   data_valid   pixel_in qualifier
//   pixel_in     unsigned luma sample
//   alpha        registered gain, 8.8 unsigned
//   beta         registered offset, 16-bit two's complement
//   coeff_valid  one-cycle pulse when alpha/beta were just updated
//   busy         registered, high while in ACCUM, DIVIDE or BETA
module auto_contrast_stats #(
  parameter int DATA_WIDTH  = 8,
  parameter int COEFF_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   frame_start,
  input  logic                   frame_end,
  input  logic                   data_valid,
  input  logic [DATA_WIDTH-1:0]  pixel_in,
  output logic [COEFF_WIDTH-1:0] alpha,
  output logic [COEFF_WIDTH-1:0] beta,
  output logic                   coeff_valid,
  output logic                   busy
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCUM,
    S_DIVIDE,
    S_BETA
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [DATA_WIDTH-1:0]  r_min;
  logic [DATA_WIDTH-1:0]  r_max;
  logic                   r_seen;
  logic [DATA_WIDTH-1:0]  r_range;
  logic [15:0]            r_dvd;
  logic [7:0]             r_rem;
  logic [15:0]            r_quot;
  logic [3:0]             r_cnt;
  logic [COEFF_WIDTH-1:0] r_alpha;
  logic [COEFF_WIDTH-1:0] r_beta;
  logic                   r_cv;
  logic                   r_busy;

  logic [DATA_WIDTH-1:0]  w_min_nxt;
  logic [DATA_WIDTH-1:0]  w_max_nxt;
  logic                   w_seen_nxt;
  logic                   w_seen_any;
  logic [DATA_WIDTH-1:0]  w_range;
  logic [8:0]             w_rem_sh;
  logic                   w_ge;
  logic [7:0]             w_rem_sub;
  logic [15:0]            w_q;
  logic [23:0]            w_prod;
  logic [15:0]            w_b;

  assign alpha       = r_alpha;
  assign beta        = r_beta;
  assign coeff_valid = r_cv;
  assign busy        = r_busy;

  // Statistics update. A pixel coinciding with frame_start seeds the new
  // frame; a pixel coinciding with frame_end still counts.
  always_comb begin
    w_min_nxt  = r_min;
    w_max_nxt  = r_max;
    w_seen_nxt = r_seen;
    if (frame_start) begin
      w_min_nxt  = data_valid ? pixel_in : '1;
      w_max_nxt  = data_valid ? pixel_in : '0;
      w_seen_nxt = data_valid;
    end else if (r_state == S_ACCUM && data_valid) begin
      w_min_nxt  = (pixel_in < r_min) ? pixel_in : r_min;
      w_max_nxt  = (pixel_in > r_max) ? pixel_in : r_max;
      w_seen_nxt = 1'b1;
    end
  end

  assign w_seen_any = r_seen | data_valid;
  assign w_range    = w_max_nxt - w_min_nxt;

  // Restoring divider step: the partial remainder never exceeds 9 bits since
  // it is always below the 8-bit divisor before the shift.
  assign w_rem_sh  = {r_rem, r_dvd[15]};
  assign w_ge      = (w_rem_sh >= {1'b0, r_range});
  assign w_rem_sub = w_rem_sh[7:0] - r_range;

  assign w_q    = (r_range == '0) ? 16'h0100 : r_quot;
  assign w_prod = 24'(r_min) * 24'(w_q);
  assign w_b    = (r_range == '0) ? 16'h0000 : 16'(24'h0 - (w_prod >> 8));

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   w_next = S_IDLE;
      S_ACCUM:  if (frame_end) w_next = w_seen_any ? S_DIVIDE : S_IDLE;
      S_DIVIDE: if (r_cnt == 4'd15) w_next = S_BETA;
      S_BETA:   w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
    if (frame_start) w_next = S_ACCUM;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_min   <= '1;
      r_max   <= '0;
      r_seen  <= 1'b0;
      r_range <= '0;
      r_dvd   <= '0;
      r_rem   <= '0;
      r_quot  <= '0;
      r_cnt   <= '0;
      r_alpha <= 16'h0100;
      r_beta  <= '0;
      r_cv    <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_cv   <= 1'b0;
      r_busy <= (w_next != S_IDLE);
      r_min  <= w_min_nxt;
      r_max  <= w_max_nxt;
      r_seen <= w_seen_nxt;

      if (r_state == S_ACCUM && w_next == S_DIVIDE) begin
        r_range <= w_range;
        r_dvd   <= 16'hFF00;
        r_rem   <= '0;
        r_quot  <= '0;
        r_cnt   <= '0;
      end else if (r_state == S_DIVIDE) begin
        r_rem  <= w_ge ? w_rem_sub : w_rem_sh[7:0];
        r_quot <= {r_quot[14:0], w_ge};
        r_dvd  <= {r_dvd[14:0], 1'b0};
        r_cnt  <= r_cnt + 4'd1;
      end

      // Commit only on a genuine BETA -> IDLE exit; a frame_start here aborts.
      if (r_state == S_BETA && w_next == S_IDLE) begin
        r_alpha <= w_q;
        r_beta  <= w_b;
        r_cv    <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_auto_contrast_stats.sv
module tb_auto_contrast_stats;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        frame_start;
  logic        frame_end;
  logic        data_valid;
  logic [7:0]  pixel_in;
  logic [15:0] alpha;
  logic [15:0] beta;
  logic        coeff_valid;
  logic        busy;

  int total = 0;
  int bad   = 0;
  int cv_count = 0;

  always #5 clk = ~clk;

  always @(posedge clk) if (coeff_valid) cv_count <= cv_count + 1;

  auto_contrast_stats #(.DATA_WIDTH(8), .COEFF_WIDTH(16)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .frame_start (frame_start),
    .frame_end   (frame_end),
    .data_valid  (data_valid),
    .pixel_in    (pixel_in),
    .alpha       (alpha),
    .beta        (beta),
    .coeff_valid (coeff_valid),
    .busy        (busy)
  );

  typedef struct {
    logic [7:0]  pa;
    logic [7:0]  pb;
    int unsigned nmid;
    logic [15:0] ea;
    logic [15:0] eb;
  } vec_t;

  vec_t       tbl[5];
  logic [7:0] pix_q[$];
  logic [15:0] exp_a, exp_b;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  // Reference: plain integer arithmetic from the coefficient definition.
  function automatic void model(input logic [7:0] mn, input logic [7:0] mx,
                                output logic [15:0] a, output logic [15:0] b);
    int unsigned range, q, p;
    range = int'(mx) - int'(mn);
    if (range == 0) begin
      a = 16'h0100;
      b = 16'h0000;
    end else begin
      q = 65280 / range;
      p = int'(mn) * q;
      a = 16'(q);
      b = 16'((65536 - (p / 256)) % 65536);
    end
  endfunction

  function automatic void q_minmax(output logic [7:0] mn, output logic [7:0] mx);
    mn = 8'd255;
    mx = 8'd0;
    foreach (pix_q[i]) begin
      if (pix_q[i] < mn) mn = pix_q[i];
      if (pix_q[i] > mx) mx = pix_q[i];
    end
  endfunction

  task automatic tick();
    @(negedge clk);
  endtask

  // First pixel rides on frame_start, last pixel rides on frame_end.
  task automatic send_frame();
    frame_start = 1'b1;
    data_valid  = 1'b1;
    pixel_in    = pix_q[0];
    tick();
    frame_start = 1'b0;
    for (int i = 1; i < pix_q.size(); i++) begin
      if ($urandom_range(0, 3) == 0) begin
        data_valid = 1'b0;
        pixel_in   = 8'($urandom);
        tick();
      end
      data_valid = 1'b1;
      pixel_in   = pix_q[i];
      frame_end  = (i == pix_q.size() - 1);
      tick();
    end
    frame_end  = 1'b0;
    data_valid = 1'b0;
  endtask

  // Called at the first negedge after the edge that sampled frame_end.
  // Random pixels keep flowing to show data outside ACCUM is ignored.
  task automatic wait_cv(output int lat, output logic [15:0] a, output logic [15:0] b);
    lat = 1;
    while (!coeff_valid && lat < 40) begin
      data_valid = 1'($urandom);
      pixel_in   = 8'($urandom);
      tick();
      lat++;
    end
    data_valid = 1'b0;
    a = alpha;
    b = beta;
    tick();
    check("cv_pulse_width", {31'd0, coeff_valid}, 32'd0);
    check("alpha_hold", {16'd0, alpha}, {16'd0, a});
  endtask

  task automatic run_and_check(input string tag, input logic [15:0] ea, input logic [15:0] eb);
    int lat;
    logic [15:0] a, b;
    int c0;
    c0 = cv_count;
    send_frame();
    wait_cv(lat, a, b);
    check({tag, "_latency"}, lat, 18);
    check({tag, "_alpha"}, {16'd0, a}, {16'd0, ea});
    check({tag, "_beta"}, {16'd0, b}, {16'd0, eb});
    check({tag, "_cv_count"}, cv_count - c0, 1);
    exp_a = ea;
    exp_b = eb;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0]  mn, mx, lo, hi;
    logic [15:0] ma, mb;
    int c0, lat;
    logic [15:0] a, b;

    tbl[0] = '{8'd50,  8'd200, 149, 16'h01B3, 16'hFFAC};
    tbl[1] = '{8'd128, 8'd128, 10,  16'h0100, 16'h0000};
    tbl[2] = '{8'd0,   8'd255, 5,   16'h0100, 16'h0000};
    tbl[3] = '{8'd10,  8'd11,  6,   16'hFF00, 16'hF60A};
    tbl[4] = '{8'd200, 8'd50,  40,  16'h01B3, 16'hFFAC};

    rst_n = 1'b0; frame_start = 1'b0; frame_end = 1'b0;
    data_valid = 1'b0; pixel_in = '0;
    #23;
    check("rst_alpha", {16'd0, alpha}, 32'h0100);
    check("rst_beta",  {16'd0, beta},  32'h0);
    check("rst_cv",    {31'd0, coeff_valid}, 32'd0);
    check("rst_busy",  {31'd0, busy}, 32'd0);
    exp_a = 16'h0100;
    exp_b = 16'h0000;
    tick();
    rst_n = 1'b1;
    tick();

    // Directed table.
    foreach (tbl[k]) begin
      lo = (tbl[k].pa < tbl[k].pb) ? tbl[k].pa : tbl[k].pb;
      hi = (tbl[k].pa < tbl[k].pb) ? tbl[k].pb : tbl[k].pa;
      pix_q.delete();
      pix_q.push_back(tbl[k].pa);
      for (int unsigned j = 0; j < tbl[k].nmid; j++)
        pix_q.push_back(8'($urandom_range(int'(lo), int'(hi))));
      pix_q.push_back(tbl[k].pb);
      run_and_check($sformatf("vec%0d", k), tbl[k].ea, tbl[k].eb);
      repeat (2) tick();
    end

    // Empty frame: no update, busy drops one cycle after frame_end.
    c0 = cv_count;
    frame_start = 1'b1; tick(); frame_start = 1'b0;
    check("empty_busy_accum", {31'd0, busy}, 32'd1);
    frame_end = 1'b1; tick(); frame_end = 1'b0;
    check("empty_busy_low", {31'd0, busy}, 32'd0);
    repeat (25) tick();
    check("empty_no_cv", cv_count - c0, 0);
    check("empty_alpha", {16'd0, alpha}, {16'd0, exp_a});
    check("empty_beta",  {16'd0, beta},  {16'd0, exp_b});

    // frame_start together with frame_end: start wins.
    frame_start = 1'b1; frame_end = 1'b1; data_valid = 1'b1; pixel_in = 8'd30;
    tick();
    frame_start = 1'b0; frame_end = 1'b0;
    check("fsfe_busy", {31'd0, busy}, 32'd1);
    pixel_in = 8'd40; frame_end = 1'b1;
    tick();
    frame_end = 1'b0; data_valid = 1'b0;
    c0 = cv_count;
    wait_cv(lat, a, b);
    model(8'd30, 8'd40, ma, mb);
    check("fsfe_latency", lat, 18);
    check("fsfe_alpha", {16'd0, a}, {16'd0, ma});
    check("fsfe_beta",  {16'd0, b}, {16'd0, mb});
    exp_a = ma; exp_b = mb;
    repeat (2) tick();

    // Abort in DIVIDE cycle 5 with a new frame 0..100.
    c0 = cv_count;
    pix_q.delete();
    for (int v = 50; v <= 200; v++) pix_q.push_back(8'(v));
    send_frame();
    repeat (4) tick();
    check("abort_busy", {31'd0, busy}, 32'd1);
    pix_q.delete();
    for (int v = 0; v <= 100; v++) pix_q.push_back(8'(v));
    model(8'd0, 8'd100, ma, mb);
    run_and_check("abort_new", ma, mb);
    check("abort_single_cv", cv_count - c0, 1);
    repeat (2) tick();

    // Reset during BETA, then a stray frame_end in IDLE.
    c0 = cv_count;
    pix_q.delete();
    pix_q.push_back(8'd10); pix_q.push_back(8'd11);
    send_frame();
    repeat (16) tick();
    check("beta_busy", {31'd0, busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("rstb_alpha", {16'd0, alpha}, 32'h0100);
    check("rstb_beta",  {16'd0, beta},  32'h0);
    check("rstb_busy",  {31'd0, busy},  32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    frame_end = 1'b1; data_valid = 1'b1; pixel_in = 8'd5;
    tick();
    frame_end = 1'b0; data_valid = 1'b0;
    repeat (25) tick();
    check("rstb_no_cv", cv_count - c0, 0);
    check("rstb_idle_busy", {31'd0, busy}, 32'd0);
    check("rstb_alpha_hold", {16'd0, alpha}, 32'h0100);
    exp_a = 16'h0100; exp_b = 16'h0000;

    // Randomized frames against the arithmetic model.
    for (int f = 0; f < 20; f++) begin
      int n, base, span, v;
      n    = $urandom_range(2, 30);
      base = $urandom_range(0, 255);
      span = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 2) : $urandom_range(0, 255);
      pix_q.delete();
      for (int j = 0; j < n; j++) begin
        v = base + $urandom_range(0, span);
        if (v > 255) v = 255;
        pix_q.push_back(8'(v));
      end
      q_minmax(mn, mx);
      model(mn, mx, ma, mb);
      run_and_check($sformatf("rnd%0d", f), ma, mb);
      repeat ($urandom_range(0, 3)) tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
